// File: rtl/rom_stream_reader.sv
// rom_stream_reader: turns a (base, count) command into enable-gated reads of a
// 1-cycle-latency synchronous ROM and streams the returned words out through a
// 2-entry buffer on a valid/ready interface, flagging the final word with out_last.
module rom_stream_reader #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] addr;
  logic [AW:0]   issue_left;
  logic [AW:0]   pop_left;
  logic          inflight;

  logic [DW-1:0] buf_mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    occ;

  logic          pop;
  logic          issue;
  logic          accept;
  logic [2:0]    credit_sum;

  // Issue credit, stream outputs and status; a read is issued only when the
  // buffer is guaranteed a free slot once every in-flight word has landed.
  always_comb begin
    out_valid  = (occ != 2'd0);
    out_data   = buf_mem[rd_ptr];
    out_last   = out_valid && (pop_left == CNT_ONE);
    pop        = out_valid && out_ready;
    credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue      = (state == RUN) && (issue_left != '0) && (credit_sum < 3'd2);
    accept     = (state == IDLE) && start;
    rom_en     = issue;
    rom_addr   = addr;
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  // Next-state logic: a zero-length command goes straight to DONE, otherwise
  // the command ends on the handshake of the word flagged as last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pop && out_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address and word counters: loaded on accept of a non-empty command, then
  // advanced on each issued read (address wraps naturally) and each popped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept && (count != '0)) begin
        addr       <= base;
        issue_left <= count;
        pop_left   <= count;
      end else begin
        if (issue) begin
          addr       <= addr + ADDR_ONE;
          issue_left <= issue_left - CNT_ONE;
        end
        if (pop) begin
          pop_left <= pop_left - CNT_ONE;
        end
      end
    end
  end

  // Two-entry FIFO: the word returned by last cycle's read is written at the
  // tail, the head advances on a handshake; capture plus pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      if (inflight) begin
        buf_mem[wr_ptr] <= rom_dout;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed bench for rom_stream_reader with a behavioural
// synchronous ROM holding mem[i] = i and a monitor that logs every handshaken word.
module tb_rom_stream_reader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          romEn;
  logic [AW-1:0] romAddr;
  logic [DW-1:0] romDout;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic          outLast;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rxData [$];
  logic          rxLast [$];
  int            romEnCount;
  int            checks;
  int            errors;

  rom_stream_reader #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rom_en    (romEn),
    .rom_addr  (romAddr),
    .rom_dout  (romDout),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_last  (outLast)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: each word holds its own address.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(i);
    end
  end

  // Synchronous enable-gated ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (romEn) begin
      romDout <= mem[romAddr];
    end
  end

  // Monitor: log handshaken words and count issued reads, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      rxData.push_back(outData);
      rxLast.push_back(outLast);
    end
    if (!rst && romEn) begin
      romEnCount++;
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] c);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = b;
    count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else cycles++;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},  32'(busy),     32'd0);
    checkOutput({tag, "_done"},  32'(done),     32'd0);
    checkOutput({tag, "_en"},    32'(romEn),    32'd0);
    checkOutput({tag, "_valid"}, 32'(outValid), 32'd0);
    checkOutput({tag, "_last"},  32'(outLast),  32'd0);
    checkOutput({tag, "_addr"},  32'(romAddr),  32'd0);
    checkOutput({tag, "_data"},  32'(outData),  32'd0);
  endtask

  initial begin
    int idx;
    int snap;
    int cyc;
    int bad;
    int lastCount;
    int delivered;
    logic [7:0] expEn;
    logic [7:0] expValid;
    logic [7:0] expLast;
    logic [7:0] expDone;
    logic [7:0] expBusy;

    checks     = 0;
    errors     = 0;
    romEnCount = 0;
    rst        = 1'b1;
    start      = 1'b0;
    base       = '0;
    count      = '0;
    outReady   = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: base 0, count 4, always ready; cycle-by-cycle timing from accept
    expEn    = 8'b0000_1111;
    expValid = 8'b0011_1100;
    expLast  = 8'b0010_0000;
    expDone  = 8'b0100_0000;
    expBusy  = 8'b0111_1111;
    snap = romEnCount;
    applyStimulus(10'd0, 11'd4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_en_c%0d", k),    32'(romEn),    32'(expEn[k]));
      checkOutput($sformatf("t1_valid_c%0d", k), 32'(outValid), 32'(expValid[k]));
      checkOutput($sformatf("t1_last_c%0d", k),  32'(outLast),  32'(expLast[k]));
      checkOutput($sformatf("t1_done_c%0d", k),  32'(done),     32'(expDone[k]));
      checkOutput($sformatf("t1_busy_c%0d", k),  32'(busy),     32'(expBusy[k]));
      if (expValid[k]) begin
        checkOutput($sformatf("t1_data_c%0d", k), 32'(outData), 32'(k - 2));
      end
    end
    checkOutput("t1_rom_reads", 32'(romEnCount - snap), 32'd4);

    // Test 2: address wrap from the top of the ROM
    idx = rxData.size();
    applyStimulus(10'(DEPTH - 2), 11'd4);
    waitDone("t2_done_seen", 50, cyc);
    checkOutput("t2_words", 32'(rxData.size() - idx), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_data%0d", i), 32'(rxData[idx + i]),
                  32'((DEPTH - 2 + i) % DEPTH));
      checkOutput($sformatf("t2_last%0d", i), 32'(rxLast[idx + i]), 32'(i == 3));
    end

    // Test 3: toggling ready plus a 5-cycle stall
    idx  = rxData.size();
    snap = romEnCount;
    applyStimulus(10'd0, 11'd8);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      outReady = ~outReady;
    end
    outReady = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      delivered = rxData.size() - idx;
      checkOutput($sformatf("t3_stall_valid%0d", s), 32'(outValid), 32'd1);
      checkOutput($sformatf("t3_stall_data%0d", s),  32'(outData),  32'(delivered));
      checkOutput($sformatf("t3_stall_last%0d", s),  32'(outLast),  32'(delivered == 7));
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    waitDone("t3_done_seen", 60, cyc);
    checkOutput("t3_words", 32'(rxData.size() - idx), 32'd8);
    bad = 0;
    lastCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (rxData[idx + i] !== DW'(i)) bad++;
      if (rxLast[idx + i]) lastCount++;
    end
    checkOutput("t3_order_errors", 32'(bad), 32'd0);
    checkOutput("t3_last_count", 32'(lastCount), 32'd1);
    checkOutput("t3_last_pos", 32'(rxLast[idx + 7]), 32'd1);
    checkOutput("t3_rom_reads", 32'(romEnCount - snap), 32'd8);

    // Test 4: zero-length command, with a second start while busy
    idx  = rxData.size();
    snap = romEnCount;
    applyStimulus(10'd0, 11'd0);
    start = 1'b1;
    base  = 10'd7;
    count = 11'd3;
    @(negedge clk);
    checkOutput("t4_done",  32'(done),     32'd1);
    checkOutput("t4_busy",  32'(busy),     32'd1);
    checkOutput("t4_en",    32'(romEn),    32'd0);
    checkOutput("t4_valid", 32'(outValid), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("t4_busy_after", 32'(busy), 32'd0);
    checkOutput("t4_done_after", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t4_rom_reads", 32'(romEnCount - snap), 32'd0);
    checkOutput("t4_words", 32'(rxData.size() - idx), 32'd0);

    // Test 5: reset in the middle of a 10-word command, then a fresh command
    idx = rxData.size();
    applyStimulus(10'd0, 11'd10);
    cyc = 0;
    while ((rxData.size() - idx) < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t5_three_words", 32'((rxData.size() - idx) >= 3), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("t5_abort");
    idx = rxData.size();
    applyStimulus(10'd5, 11'd2);
    waitDone("t5_done_seen", 30, cyc);
    checkOutput("t5_done_cycle", 32'(cyc), 32'd4);
    checkOutput("t5_words", 32'(rxData.size() - idx), 32'd2);
    checkOutput("t5_data0", 32'(rxData[idx]),     32'd5);
    checkOutput("t5_data1", 32'(rxData[idx + 1]), 32'd6);
    checkOutput("t5_last0", 32'(rxLast[idx]),     32'd0);
    checkOutput("t5_last1", 32'(rxLast[idx + 1]), 32'd1);

    // Test 6: whole ROM from base 3, wrapping, at one word per cycle
    idx  = rxData.size();
    snap = romEnCount;
    applyStimulus(10'd3, 11'(DEPTH));
    waitDone("t6_done_seen", DEPTH + 100, cyc);
    checkOutput("t6_done_cycle", 32'(cyc), 32'(DEPTH + 2));
    checkOutput("t6_words", 32'(rxData.size() - idx), 32'(DEPTH));
    bad = 0;
    lastCount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rxData[idx + i] !== DW'((3 + i) % DEPTH)) bad++;
      if (rxLast[idx + i]) lastCount++;
    end
    checkOutput("t6_order_errors", 32'(bad), 32'd0);
    checkOutput("t6_first", 32'(rxData[idx]), 32'd3);
    checkOutput("t6_final", 32'(rxData[idx + DEPTH - 1]), 32'd2);
    checkOutput("t6_last_count", 32'(lastCount), 32'd1);
    checkOutput("t6_last_pos", 32'(rxLast[idx + DEPTH - 1]), 32'd1);
    checkOutput("t6_rom_reads", 32'(romEnCount - snap), 32'(DEPTH));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
